// File: rtl/cordic_table_loader.sv
// cordic_table_loader: packs host words into CORDIC table entries and writes them
// out one entry at a time. A burst ends with an XOR checksum word. The checksum
// word is never written to the table; it only sets or clears err.
module cordic_table_loader #(
  parameter int DATA_W = 16,
  parameter int WPE    = 3,
  parameter int IDX_W  = 6,
  parameter int DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IDX_W-1:0]        base_idx,
  input  logic [IDX_W:0]          num_entries,
  input  logic                    s_valid,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    s_ready,
  output logic                    wen,
  output logic [IDX_W-1:0]        index_wri,
  output logic [DATA_W*WPE-1:0]   D,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int ENTRY_W = DATA_W * WPE;
  localparam int WCNT_W  = (WPE > 1) ? $clog2(WPE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    base_q, base_d;
  logic [IDX_W:0]      num_q, num_d;
  logic [IDX_W:0]      entry_cnt_q, entry_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]   chk_q, chk_d;
  logic [ENTRY_W-1:0]  asm_q, asm_d;

  logic                s_ready_q, s_ready_d;
  logic                wen_q, wen_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [ENTRY_W-1:0]  data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer;
  logic                num_legal;
  logic                last_word;
  logic                more_entries;

  // A word moves only when the host offers it and we advertised ready.
  assign xfer         = s_valid && s_ready_q;
  assign num_legal    = (num_entries != '0) && (num_entries <= (IDX_W+1)'(DEPTH));
  assign last_word    = (word_cnt_q == WCNT_W'(WPE - 1));
  assign more_entries = ((entry_cnt_q + (IDX_W+1)'(1)) != num_q);

  // Next-state and next-output logic; every output is registered from its _d value.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    entry_cnt_d = entry_cnt_q;
    word_cnt_d  = word_cnt_q;
    chk_d       = chk_q;
    asm_d       = asm_q;
    index_d     = index_q;
    data_d      = data_q;
    err_d       = err_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_legal) begin
            base_d      = base_idx;
            num_d       = num_entries;
            entry_cnt_d = '0;
            word_cnt_d  = '0;
            chk_d       = '0;
            err_d       = 1'b0;
            state_d     = S_COLLECT;
          end else begin
            // Bad length: flag it immediately and never touch the table.
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (xfer) begin
          // Most significant word arrives first.
          asm_d[(WPE - 1 - int'(word_cnt_q)) * DATA_W +: DATA_W] = s_data;
          chk_d = chk_q ^ s_data;
          if (last_word) begin
            word_cnt_d = '0;
            index_d    = base_q + entry_cnt_q[IDX_W-1:0];
            data_d     = asm_d;
            state_d    = S_WRITE;
          end else begin
            word_cnt_d = word_cnt_q + WCNT_W'(1);
          end
        end
      end

      S_WRITE: begin
        entry_cnt_d = entry_cnt_q + (IDX_W+1)'(1);
        state_d     = more_entries ? S_COLLECT : S_CHECK;
      end

      S_CHECK: begin
        if (xfer) begin
          err_d   = (s_data != chk_q);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake and status outputs follow the state being entered.
    wen_d     = (state_d == S_WRITE);
    s_ready_d = (state_d == S_COLLECT) || (state_d == S_CHECK);
    busy_d    = (state_d == S_COLLECT) || (state_d == S_WRITE) || (state_d == S_CHECK);
    done_d    = done_d || (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      entry_cnt_q <= '0;
      word_cnt_q  <= '0;
      chk_q       <= '0;
      asm_q       <= '0;
      s_ready_q   <= 1'b0;
      wen_q       <= 1'b0;
      index_q     <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      entry_cnt_q <= entry_cnt_d;
      word_cnt_q  <= word_cnt_d;
      chk_q       <= chk_d;
      asm_q       <= asm_d;
      s_ready_q   <= s_ready_d;
      wen_q       <= wen_d;
      index_q     <= index_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign wen       = wen_q;
  assign index_wri = index_q;
  assign D         = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cordic_table_loader.sv
// Bench for cordic_table_loader: table of bursts, write scoreboard, and
// hand-written sequences for bad lengths and reset in the middle of a burst.
module tb_cordic_table_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  base_idx;
  logic [6:0]  num_entries;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        wen;
  logic [5:0]  index_wri;
  logic [47:0] D;
  logic        busy;
  logic        done;
  logic        err;

  cordic_table_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_idx    (base_idx),
    .num_entries (num_entries),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .wen         (wen),
    .index_wri   (index_wri),
    .D           (D),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] base;
    logic [6:0] num;
    int         seed;
    bit         fixed;
    bit         bad_chk;
    bit         gaps;
    bit         inj_start;
    bit         exp_err;
  } vec_t;

  typedef struct {
    logic [5:0]  idx;
    logic [47:0] d;
  } wr_t;

  wr_t   exp_q[$];
  wr_t   mon_e;
  vec_t  vecs[7];
  int    checks = 0;
  int    errors = 0;
  int    wen_count = 0;
  logic  rst_prev = 1'b1;
  logic [5:0]  last_idx = '0;
  logic [47:0] last_d = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wgen(input int seed, input int k);
    logic [31:0] x;
    x = 32'(seed) * 32'h9E3779B1 + 32'(k) * 32'h85EBCA6B;
    x = x ^ (x >> 15);
    return x[15:0];
  endfunction

  // Reset as seen by the DUT at the last rising edge.
  always @(posedge clk) rst_prev = reset;

  // Write monitor: every wen pops the scoreboard; index/D must hold otherwise.
  always @(negedge clk) begin
    if (rst_prev) begin
      last_idx = '0;
      last_d   = '0;
    end else if (wen) begin
      wen_count++;
      check("wen_s_ready_low", 64'(s_ready), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wen: got write idx=%0d D=0x%0h, required no write", index_wri, D);
      end else begin
        mon_e = exp_q.pop_front();
        check("wen_index", 64'(index_wri), 64'(mon_e.idx));
        check("wen_data", 64'(D), 64'(mon_e.d));
      end
      last_idx = index_wri;
      last_d   = D;
    end else begin
      check("hold_index", 64'(index_wri), 64'(last_idx));
      check("hold_data", 64'(D), 64'(last_d));
    end
  end

  // Offer one word until it is accepted; called and returns at a falling edge.
  task automatic send_word(input logic [15:0] w, input bit gaps);
    bit v;
    bit r;
    bit sent;
    int n;
    sent = 1'b0;
    n = 0;
    while (!sent) begin
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: s_ready=%0b after %0d cycles, required a transfer", s_ready, n);
        s_valid = 1'b0;
        return;
      end
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_valid = v;
      s_data  = v ? w : 16'($urandom);
      r = s_ready;
      @(negedge clk);
      n++;
      if (v && r) sent = 1'b1;
    end
    s_valid = 1'b0;
  endtask

  task automatic start_burst(input logic [5:0] b, input logic [6:0] n);
    start       = 1'b1;
    base_idx    = b;
    num_entries = n;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic run_burst(input vec_t v, input int id);
    logic [15:0] fw[3];
    logic [15:0] w[3];
    logic [15:0] chk;
    logic [15:0] cw;
    wr_t         e;
    int          base_cnt;
    int          n;
    fw[0] = 16'h1234;
    fw[1] = 16'h5678;
    fw[2] = 16'h9ABC;
    chk = '0;
    start_burst(v.base, v.num);
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_cleared", 64'(err), 64'd0);
    check("s_ready_collect", 64'(s_ready), 64'd1);
    base_cnt = wen_count;
    for (int en = 0; en < int'(v.num); en++) begin
      for (int k = 0; k < 3; k++) begin
        w[k] = v.fixed ? fw[k] : wgen(v.seed, en * 3 + k);
        chk  = chk ^ w[k];
        if (k == 2) begin
          e.idx = 6'(int'(v.base) + en);
          e.d   = {w[0], w[1], w[2]};
          exp_q.push_back(e);
        end
        if (v.inj_start && en == 0 && k == 1) begin
          start       = 1'b1;
          base_idx    = v.base + 6'd7;
          num_entries = 7'd5;
        end
        send_word(w[k], v.gaps);
        start = 1'b0;
      end
    end
    if (v.bad_chk) cw = v.fixed ? 16'h0000 : ~chk;
    else           cw = chk;
    send_word(cw, v.gaps);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", 64'(done), 64'd1);
    check("done_err", 64'(err), 64'(v.exp_err));
    check("busy_at_done", 64'(busy), 64'd0);
    check("wen_count", 64'(wen_count - base_cnt), 64'(v.num));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("err_held", 64'(err), 64'(v.exp_err));
    check("s_ready_idle", 64'(s_ready), 64'd0);
    $display("burst %0d: base=%0d num=%0d gaps=%0b err=%0b writes=%0d", id, v.base, v.num,
             v.gaps, err, wen_count - base_cnt);
  endtask

  initial begin
    int wc;
    logic [6:0] bad_nums[3];

    //        base   num    seed fixed bad gaps inj exp_err
    vecs[0] = '{6'd0,  7'd1,  0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{6'd62, 7'd4,  11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{6'd0,  7'd1,  0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{6'd62, 7'd4,  11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{6'd10, 7'd2,  23, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{6'd40, 7'd64, 37, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{6'd5,  7'd3,  41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset held three cycles with random inputs: every output must be zero.
    reset = 1'b1;
    start = 1'b0;
    base_idx = '0;
    num_entries = '0;
    s_valid = 1'b0;
    s_data = '0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      start       = 1'($urandom);
      base_idx    = 6'($urandom);
      num_entries = 7'($urandom);
      s_valid     = 1'($urandom);
      s_data      = 16'($urandom);
      @(negedge clk);
      check("reset_outputs", {7'd0, s_ready, wen, index_wri, D, busy, done, err}, 64'd0);
    end
    start = 1'b0;
    s_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_burst(vecs[i], i);

    // Illegal lengths: immediate done with err, no writes, no busy.
    bad_nums[0] = 7'd0;
    bad_nums[1] = 7'd65;
    bad_nums[2] = 7'd127;
    for (int i = 0; i < 3; i++) begin
      wc = wen_count;
      start_burst(6'd3, bad_nums[i]);
      check("bad_num_done", 64'(done), 64'd1);
      check("bad_num_err", 64'(err), 64'd1);
      check("bad_num_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("bad_num_done_clear", 64'(done), 64'd0);
      check("bad_num_err_held", 64'(err), 64'd1);
      check("bad_num_no_wen", 64'(wen_count - wc), 64'd0);
      $display("bad start: num=%0d err=%0b", bad_nums[i], err);
    end

    // Reset after the second word of entry 1: entry 0 stays written, entry 1 is dropped.
    begin
      wr_t e;
      logic [15:0] w[3];
      start_burst(6'd20, 7'd3);
      for (int k = 0; k < 3; k++) w[k] = wgen(77, k);
      e.idx = 6'd20;
      e.d   = {w[0], w[1], w[2]};
      exp_q.push_back(e);
      for (int k = 0; k < 3; k++) send_word(w[k], 1'b0);
      send_word(wgen(77, 3), 1'b0);
      send_word(wgen(77, 4), 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", 64'(busy), 64'd0);
      check("midreset_s_ready", 64'(s_ready), 64'd0);
      check("midreset_wen", 64'(wen), 64'd0);
      check("midreset_done", 64'(done), 64'd0);
      wc = wen_count;
      for (int i = 0; i < 5; i++) begin
        s_valid = 1'b1;
        s_data  = wgen(77, 5);
        @(negedge clk);
        check("midreset_quiet_done", 64'(done), 64'd0);
      end
      s_valid = 1'b0;
      check("midreset_no_wen", 64'(wen_count - wc), 64'd0);
      check("midreset_scoreboard", 64'(exp_q.size()), 64'd0);
      $display("mid-burst reset: busy=%0b writes_after=%0d", busy, wen_count - wc);
    end

    run_burst(vecs[1], 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
